// File: rtl/alu_wb_if.sv
// Handshake and data bundle between the ALU, the writeback stage and the register file.
interface alu_wb_if #(parameter int DST_W = 3);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_result;
  logic [7:0]       in_flags;
  logic [DST_W-1:0] in_dst;
  logic             in_wr_flags;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_result;
  logic [DST_W-1:0] out_dst;
  logic [7:0]       flags_q;
  logic [7:0]       commit_cnt;

  modport master (
    output in_valid, in_result, in_flags, in_dst, in_wr_flags, flush, out_ready,
    input  in_ready, out_valid, out_result, out_dst, flags_q, commit_cnt
  );

  modport slave (
    input  in_valid, in_result, in_flags, in_dst, in_wr_flags, flush, out_ready,
    output in_ready, out_valid, out_result, out_dst, flags_q, commit_cnt
  );
endinterface

// File: rtl/alu_writeback.sv
// Two-entry in-order writeback buffer with architectural flags register and commit counter.
// Optional macro ALU_WB_STICKY_OV_EN makes flags_q[5] a sticky overflow bit.
//
// state | meaning
// EMPTY | no buffered entries
// ONE   | head valid, tail free
// FULL  | head and tail valid, upstream stalled
module alu_writeback #(parameter int DST_W = 3) (
  input  logic   clk,
  input  logic   rst,
  alu_wb_if.slave bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;

  occ_t             occ;
  logic [7:0]       head_result, tail_result;
  logic [DST_W-1:0] head_dst, tail_dst;
  logic [4:0]       head_flags, tail_flags;
  logic             head_wr, tail_wr;
  logic [7:0]       flags_r;
  logic [7:0]       cnt_r;
  logic             push, pop;
  logic             unused_flags_hi;

  // Upper flag bits are architecturally zero from the ALU.
  assign unused_flags_hi = ^bus.in_flags[7:5];

  assign bus.in_ready   = (occ != FULL);
  assign bus.out_valid  = (occ != EMPTY);
  assign bus.out_result = head_result;
  assign bus.out_dst    = head_dst;
  assign bus.flags_q    = flags_r;
  assign bus.commit_cnt = cnt_r;

  // A flush cancels both the push and the commit of the same cycle.
  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ         <= EMPTY;
      head_result <= '0;
      head_dst    <= '0;
      head_flags  <= '0;
      head_wr     <= 1'b0;
      tail_result <= '0;
      tail_dst    <= '0;
      tail_flags  <= '0;
      tail_wr     <= 1'b0;
      flags_r     <= '0;
      cnt_r       <= '0;
    end else begin
      if (bus.flush) begin
        occ <= EMPTY;
      end else begin
        case (occ)
          EMPTY: if (push) begin
            occ         <= ONE;
            head_result <= bus.in_result;
            head_dst    <= bus.in_dst;
            head_flags  <= bus.in_flags[4:0];
            head_wr     <= bus.in_wr_flags;
          end
          ONE: if (push && pop) begin
            head_result <= bus.in_result;
            head_dst    <= bus.in_dst;
            head_flags  <= bus.in_flags[4:0];
            head_wr     <= bus.in_wr_flags;
          end else if (push) begin
            occ         <= FULL;
            tail_result <= bus.in_result;
            tail_dst    <= bus.in_dst;
            tail_flags  <= bus.in_flags[4:0];
            tail_wr     <= bus.in_wr_flags;
          end else if (pop) begin
            occ <= EMPTY;
          end
          FULL: if (pop) begin
            occ         <= ONE;
            head_result <= tail_result;
            head_dst    <= tail_dst;
            head_flags  <= tail_flags;
            head_wr     <= tail_wr;
          end
          default: occ <= EMPTY;
        endcase
      end

      if (pop) begin
        cnt_r <= cnt_r + 8'd1;
        if (head_wr) begin
`ifdef ALU_WB_STICKY_OV_EN
          flags_r <= {2'b00, flags_r[5] | head_flags[2], head_flags};
`else
          flags_r <= {3'b000, head_flags};
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed vector table, reset/wrap sequences, random vs queue model.
module tb_alu_writeback;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

`ifdef ALU_WB_STICKY_OV_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_wb_if #(.DST_W(3)) bus ();
  alu_writeback #(.DST_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic       iv;
    logic [7:0] res;
    logic [2:0] dst;
    logic [7:0] fl;
    logic       wr;
    logic       fsh;
    logic       ordy;
    logic       e_ov;
    logic [7:0] e_res;
    logic [2:0] e_dst;
    logic       e_ir;
    logic [7:0] e_fl;
    logic [7:0] e_fls;
    logic [7:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [2:0] dst;
    logic [7:0] fl;
    logic       wr;
  } ent_t;

  vec_t vecs[20];
  ent_t q[$];
  logic [7:0] m_fl;
  logic [7:0] m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] res, input logic [2:0] dst,
                       input logic [7:0] fl, input logic wr, input logic fsh, input logic ordy);
    bus.in_valid    = iv;
    bus.in_result   = res;
    bus.in_dst      = dst;
    bus.in_flags    = fl;
    bus.in_wr_flags = wr;
    bus.flush       = fsh;
    bus.out_ready   = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk({nm, ".out_valid"}, 32'(bus.out_valid), 0);
    chk({nm, ".in_ready"}, 32'(bus.in_ready), 1);
    chk({nm, ".out_result"}, 32'(bus.out_result), 0);
    chk({nm, ".out_dst"}, 32'(bus.out_dst), 0);
    chk({nm, ".flags_q"}, 32'(bus.flags_q), 0);
    chk({nm, ".commit_cnt"}, 32'(bus.commit_cnt), 0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'h2A, 3'd3, 8'h00, 1'b1, 1'b0, 1'b1,  1'b1, 8'h2A, 3'd3, 1'b1, 8'h00, 8'h00, 8'd0};
    vecs[1]  = '{1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b0, 8'h00, 3'd0, 1'b1, 8'h00, 8'h00, 8'd1};
    vecs[2]  = '{1'b1, 8'h11, 3'd1, 8'h01, 1'b1, 1'b0, 1'b0,  1'b1, 8'h11, 3'd1, 1'b1, 8'h00, 8'h00, 8'd1};
    vecs[3]  = '{1'b1, 8'h22, 3'd2, 8'h02, 1'b0, 1'b0, 1'b0,  1'b1, 8'h11, 3'd1, 1'b0, 8'h00, 8'h00, 8'd1};
    vecs[4]  = '{1'b1, 8'h33, 3'd3, 8'h00, 1'b1, 1'b0, 1'b0,  1'b1, 8'h11, 3'd1, 1'b0, 8'h00, 8'h00, 8'd1};
    vecs[5]  = '{1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b1, 8'h22, 3'd2, 1'b1, 8'h01, 8'h01, 8'd2};
    vecs[6]  = '{1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b0, 8'h00, 3'd0, 1'b1, 8'h01, 8'h01, 8'd3};
    vecs[7]  = '{1'b1, 8'h44, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0,  1'b1, 8'h44, 3'd4, 1'b1, 8'h01, 8'h01, 8'd3};
    vecs[8]  = '{1'b1, 8'h55, 3'd5, 8'h10, 1'b1, 1'b0, 1'b1,  1'b1, 8'h55, 3'd5, 1'b1, 8'h01, 8'h01, 8'd4};
    vecs[9]  = '{1'b1, 8'h66, 3'd6, 8'h04, 1'b1, 1'b0, 1'b1,  1'b1, 8'h66, 3'd6, 1'b1, 8'h10, 8'h10, 8'd5};
    vecs[10] = '{1'b1, 8'h77, 3'd7, 8'h08, 1'b1, 1'b0, 1'b1,  1'b1, 8'h77, 3'd7, 1'b1, 8'h04, 8'h24, 8'd6};
    vecs[11] = '{1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b0, 8'h00, 3'd0, 1'b1, 8'h08, 8'h28, 8'd7};
    vecs[12] = '{1'b1, 8'h01, 3'd1, 8'h1F, 1'b1, 1'b0, 1'b0,  1'b1, 8'h01, 3'd1, 1'b1, 8'h08, 8'h28, 8'd7};
    vecs[13] = '{1'b1, 8'h02, 3'd2, 8'h03, 1'b1, 1'b0, 1'b0,  1'b1, 8'h01, 3'd1, 1'b0, 8'h08, 8'h28, 8'd7};
    vecs[14] = '{1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1,  1'b0, 8'h00, 3'd0, 1'b1, 8'h08, 8'h28, 8'd7};
    vecs[15] = '{1'b1, 8'h03, 3'd3, 8'h1F, 1'b1, 1'b1, 1'b1,  1'b0, 8'h00, 3'd0, 1'b1, 8'h08, 8'h28, 8'd7};
    vecs[16] = '{1'b1, 8'h04, 3'd0, 8'h1F, 1'b1, 1'b0, 1'b0,  1'b1, 8'h04, 3'd0, 1'b1, 8'h08, 8'h28, 8'd7};
    vecs[17] = '{1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b0, 8'h00, 3'd0, 1'b1, 8'h1F, 8'h3F, 8'd8};
    vecs[18] = '{1'b1, 8'h05, 3'd5, 8'h00, 1'b1, 1'b0, 1'b0,  1'b1, 8'h05, 3'd5, 1'b1, 8'h1F, 8'h3F, 8'd8};
    vecs[19] = '{1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1,  1'b0, 8'h00, 3'd0, 1'b1, 8'h00, 8'h20, 8'd9};

    drive(1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    #2;
    do_reset("reset");

    // Directed table
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].iv, vecs[i].res, vecs[i].dst, vecs[i].fl, vecs[i].wr, vecs[i].fsh, vecs[i].ordy);
      tick();
      chk($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ir));
      if (vecs[i].e_ov) begin
        chk($sformatf("vec%0d.out_result", i), 32'(bus.out_result), 32'(vecs[i].e_res));
        chk($sformatf("vec%0d.out_dst", i), 32'(bus.out_dst), 32'(vecs[i].e_dst));
      end
      chk($sformatf("vec%0d.flags_q", i), 32'(bus.flags_q), 32'(STICKY ? vecs[i].e_fls : vecs[i].e_fl));
      chk($sformatf("vec%0d.commit_cnt", i), 32'(bus.commit_cnt), 32'(vecs[i].e_cnt));
    end

    // Reset mid-operation with a full buffer and out_ready high: no commit, all cleared
    drive(1'b1, 8'hA1, 3'd1, 8'h04, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'hA2, 3'd2, 8'h04, 1'b1, 1'b0, 1'b0);
    tick();
    chk("midrst.full", 32'(bus.in_ready), 0);
    drive(1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    do_reset("midrst");

    // Commit counter wrap: 255 commits, then one more
    drive(1'b1, 8'h5A, 3'd2, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) tick();
    chk("wrap.cnt255", 32'(bus.commit_cnt), 255);
    drive(1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    chk("wrap.cnt0", 32'(bus.commit_cnt), 0);
    chk("wrap.empty", 32'(bus.out_valid), 0);

    // Random traffic against a queue model
    do_reset("rnd_reset");
    q.delete();
    m_fl = 8'h00;
    m_cnt = 8'h00;
    for (int c = 0; c < 600; c++) begin
      logic iv, wr, fsh, ordy, can_push;
      logic [7:0] res, fl;
      logic [2:0] dst;
      ent_t e;
      iv   = 1'($urandom_range(0, 1));
      res  = 8'($urandom);
      dst  = 3'($urandom);
      fl   = {3'b000, 5'($urandom)};
      wr   = 1'($urandom_range(0, 1));
      fsh  = ($urandom_range(0, 15) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      drive(iv, res, dst, fl, wr, fsh, ordy);
      can_push = (q.size() < 2);
      if (fsh) begin
        q.delete();
      end else begin
        if (q.size() > 0 && ordy) begin
          e = q.pop_front();
          m_cnt = m_cnt + 8'd1;
          if (e.wr) begin
            if (STICKY) m_fl = {2'b00, m_fl[5] | e.fl[2], e.fl[4:0]};
            else        m_fl = {3'b000, e.fl[4:0]};
          end
        end
        if (iv && can_push) q.push_back('{res, dst, fl, wr});
      end
      tick();
      chk("rnd.out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      chk("rnd.in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      if (q.size() > 0) begin
        chk("rnd.out_result", 32'(bus.out_result), 32'(q[0].res));
        chk("rnd.out_dst", 32'(bus.out_dst), 32'(q[0].dst));
      end
      chk("rnd.flags_q", 32'(bus.flags_q), 32'(m_fl));
      chk("rnd.commit_cnt", 32'(bus.commit_cnt), 32'(m_cnt));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DST_W, default 3: width of the destination register index.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  upstream ALU result valid.
REQ-005 in_ready  output  1  stage can accept an entry this cycle.
REQ-006 in_result  input  8  ALU out.
REQ-007 in_flags  input  8  ALU flags {3'b0, parity, zero, overflow, negative, carry}.
REQ-008 in_dst  input  DST_W  destination register index.
REQ-009 in_wr_flags  input  1  entry updates the flags register on commit.
REQ-010 flush  input  1  discard all buffered entries.
REQ-011 out_valid  output  1  head entry available to the register file.
REQ-012 out_ready  input  1  register file consumes head entry.
REQ-013 out_result  output  8  head entry result.
REQ-014 out_dst  output  DST_W  head entry destination.
REQ-015 flags_q  output  8  architectural flags register.
REQ-016 commit_cnt  output  8  count of committed entries.

Function
REQ-017 The block SHALL be a 2-entry in-order FIFO with occupancy states EMPTY(0), ONE(1), FULL(2).
REQ-018 in_ready SHALL be 1 exactly when occupancy is below 2, derived from registered occupancy only.
REQ-019 Push SHALL occur when in_valid && in_ready; pop (commit) SHALL occur when out_valid && out_ready.
REQ-020 out_valid SHALL be 1 exactly when occupancy is nonzero; an entry pushed at edge N SHALL appear at the outputs after edge N (1-cycle latency) if the FIFO was empty.
REQ-021 Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop; FULL->ONE on pop (no push possible).
REQ-022 Entries SHALL leave in arrival order; out_result/out_dst SHALL hold stable while out_valid && !out_ready.
REQ-023 On commit with the entry's wr_flags set, flags_q SHALL load the entry's flags at that edge; otherwise flags_q SHALL hold.
REQ-024 commit_cnt SHALL increment by 1 on each commit, wrapping 255->0.
REQ-025 flush SHALL set occupancy to EMPTY at the next edge; any same-cycle push and pop SHALL be dropped (no flags_q or commit_cnt update).
REQ-026 When empty, out_result/out_dst SHALL retain the last stored head value (don't-care for checking).

Reset
REQ-027 rst SHALL take priority over flush and all handshakes.
REQ-028 After rst: occupancy EMPTY, out_valid 0, in_ready 1, out_result 0, out_dst 0, flags_q 0, commit_cnt 0, storage 0.
REQ-029 rst asserted mid-operation SHALL discard buffered entries with no commit on that edge.

Configuration
REQ-030 Macro ALU_WB_STICKY_OV_EN: when defined, flags_q[5] SHALL be a sticky overflow bit set on any commit of an entry with wr_flags set and flags[2]=1, cleared only by rst; flush SHALL not clear it.
REQ-031 Without ALU_WB_STICKY_OV_EN, flags_q[7:5] SHALL always be 0.

Verification
REQ-032 After rst, push result 0x2A, dst 3, flags 0x00, wr_flags 1, out_ready 1 -> next cycle out_valid 1, out_result 0x2A, out_dst 3; following edge flags_q 0x00, commit_cnt 1.
REQ-033 out_ready 0, push 0x11 then 0x22 -> in_ready 0 after second push; third in_valid ignored; release out_ready -> 0x11 then 0x22 committed in order.
REQ-034 Occupancy ONE, simultaneous push 0x55 and pop -> occupancy stays ONE, head becomes 0x55, commit_cnt +1.
REQ-035 Commit entry with flags 0x04 (overflow), wr_flags 1, then entry flags 0x08, wr_flags 1 -> flags_q 0x08 without macro, 0x28 with ALU_WB_STICKY_OV_EN.
REQ-036 FULL with flush and out_ready 1 same cycle -> next cycle out_valid 0, in_ready 1, commit_cnt and flags_q unchanged.
REQ-037 commit_cnt preloaded to 255 by 255 commits, one more commit -> commit_cnt 0.
